// File: rtl/intra_edge_pkg.sv
// Shared constants for the AV1 intra-edge upsample decision (get_upsample()).
package intra_edge_pkg;

   localparam int DIM_W_DEFAULT          = 10;
   localparam int DELTA_W_DEFAULT        = 10;

   localparam int UPSAMPLE_DELTA_LIMIT   = 40;
   localparam int UPSAMPLE_WH_MAX_NORMAL = 16;
   localparam int UPSAMPLE_WH_MAX_SMOOTH = 8;

endpackage

// File: rtl/intra_edge_upsample_core.sv
// Combinational upsample decision for one reference edge: block size, edge
// filter type and signed angle delta in, upsample flag out.
module intra_edge_upsample_core
   import intra_edge_pkg::*;
#(
   parameter int DIM_W   = DIM_W_DEFAULT,
   parameter int DELTA_W = DELTA_W_DEFAULT
) (
   input  logic [DIM_W-1:0]          w,
   input  logic [DIM_W-1:0]          h,
   input  logic                      filterType,
   input  logic signed [DELTA_W-1:0] delta,
   output logic                      upsample
);

   localparam logic [DELTA_W:0] DELTA_LIMIT = (DELTA_W+1)'(UPSAMPLE_DELTA_LIMIT);
   localparam logic [DIM_W:0]   WH_NORMAL   = (DIM_W+1)'(UPSAMPLE_WH_MAX_NORMAL);
   localparam logic [DIM_W:0]   WH_SMOOTH   = (DIM_W+1)'(UPSAMPLE_WH_MAX_SMOOTH);

   // One extra bit so the most negative delta has a representable magnitude.
   function automatic logic [DELTA_W:0] abs_ext(input logic signed [DELTA_W-1:0] x);
      logic signed [DELTA_W:0] x_ext;
      logic signed [DELTA_W:0] x_neg;
      x_ext = {x[DELTA_W-1], x};
      x_neg = -x_ext;
      return x_ext[DELTA_W] ? x_neg : x_ext;
   endfunction

   logic [DELTA_W:0] d;
   logic [DIM_W:0]   blk_wh;

   assign d      = abs_ext(delta);
   assign blk_wh = {1'b0, w} + {1'b0, h};

   always_comb begin
      upsample = 1'b0;
      if ((d != '0) && (d < DELTA_LIMIT)) begin
         upsample = filterType ? (blk_wh <= WH_SMOOTH) : (blk_wh <= WH_NORMAL);
      end
   end

endmodule

// File: rtl/intra_edge_upsample_selection.sv
// Registered AV1 intra-edge upsample decision, one-cycle latency.
// Define INTRA_EDGE_UPSAMPLE_DUAL_EN to add a parallel left-edge decision.
module intra_edge_upsample_selection
   import intra_edge_pkg::*;
#(
   parameter int DIM_W   = DIM_W_DEFAULT,
   parameter int DELTA_W = DELTA_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [DIM_W-1:0]          w,
   input  logic [DIM_W-1:0]          h,
   input  logic                      filterType,
   input  logic signed [DELTA_W-1:0] delta,
`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
   input  logic signed [DELTA_W-1:0] delta_left,
`endif
   output logic                      out_valid,
`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
   output logic                      useUpsample,
   output logic                      useUpsampleLeft
`else
   output logic                      useUpsample
`endif
);

   logic upsample_above_c;
   logic vld_p0;
   logic upsample_above_p0;

   intra_edge_upsample_core #(
      .DIM_W   (DIM_W),
      .DELTA_W (DELTA_W)
   ) u_core_above (
      .w          (w),
      .h          (h),
      .filterType (filterType),
      .delta      (delta),
      .upsample   (upsample_above_c)
   );

`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
   logic upsample_left_c;
   logic upsample_left_p0;

   intra_edge_upsample_core #(
      .DIM_W   (DIM_W),
      .DELTA_W (DELTA_W)
   ) u_core_left (
      .w          (w),
      .h          (h),
      .filterType (filterType),
      .delta      (delta_left),
      .upsample   (upsample_left_c)
   );
`endif

   // Stage p0: results load only on accepted inputs, so idle-cycle X never lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0            <= 1'b0;
         upsample_above_p0 <= 1'b0;
`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
         upsample_left_p0  <= 1'b0;
`endif
      end else begin
         vld_p0 <= in_valid;
         if (in_valid) begin
            upsample_above_p0 <= upsample_above_c;
`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
            upsample_left_p0  <= upsample_left_c;
`endif
         end
      end
   end

   assign out_valid   = vld_p0;
   assign useUpsample = upsample_above_p0;
`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
   assign useUpsampleLeft = upsample_left_p0;
`endif

endmodule

// File: tb/tb_intra_edge_upsample_selection.sv
// Self-checking bench for intra_edge_upsample_selection against a behavioural model.
module tb_intra_edge_upsample_selection;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [9:0]        w = '0;
   logic [9:0]        h = '0;
   logic              filterType = 1'b0;
   logic signed [9:0] delta = '0;
   logic signed [9:0] delta_left = '0;
   logic              out_valid;
   logic              useUpsample;
   logic              useUpsampleLeft;

   int n_cmp = 0;
   int n_err = 0;
   logic exp_up = 1'b0;
   logic exp_left = 1'b0;

   always #5 clk = ~clk;

   intra_edge_upsample_selection #(.DIM_W(10), .DELTA_W(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .w           (w),
      .h           (h),
      .filterType  (filterType),
      .delta       (delta),
`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
      .delta_left  (delta_left),
      .useUpsampleLeft (useUpsampleLeft),
`endif
      .out_valid   (out_valid),
      .useUpsample (useUpsample)
   );

`ifndef INTRA_EDGE_UPSAMPLE_DUAL_EN
   assign useUpsampleLeft = 1'b0;
`endif

   // Reference: AV1 get_upsample() in plain integer arithmetic.
   function automatic logic ref_upsample(input int bw, input int bh, input bit ft, input int dlt);
      int d;
      d = (dlt < 0) ? -dlt : dlt;
      if (d == 0 || d >= 40) return 1'b0;
      if (ft) return (bw + bh) <= 8;
      return (bw + bh) <= 16;
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_cmp++;
      if (useUpsample !== 1'b0) begin
         n_err++;
         $display("FAIL reset_useUpsample: got %b expected 0", useUpsample);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      int  tw[11]  = '{4, 4, 4, 4, 4,    8, 8,  4, 4, 8, 4};
      int  th[11]  = '{4, 4, 4, 4, 4,    8, 16, 4, 8, 9, 5};
      bit  tf[11]  = '{0, 0, 0, 0, 0,    0, 0,  1, 1, 0, 1};
      int  td[11]  = '{39, 40, 0, -39, -512, 10, 10, 10, 10, 10, 1};
      bit  te[11]  = '{1, 0, 0, 1, 0,    1, 0,  1, 0, 0, 0};
      for (int i = 0; i < 11; i++) begin
         in_valid   = 1'b1;
         w          = 10'(tw[i]);
         h          = 10'(th[i]);
         filterType = tf[i];
         delta      = 10'(td[i]);
         @(posedge clk);
         #1;
         exp_up = te[i];
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL directed_valid[%0d]: got %b expected 1", i, out_valid);
         end
         n_cmp++;
         if (useUpsample !== te[i]) begin
            n_err++;
            $display("FAIL directed[%0d] w=%0d h=%0d ft=%0d delta=%0d: got %b expected %b",
                     i, tw[i], th[i], tf[i], td[i], useUpsample, te[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         in_valid   = 1'b1;
         w          = 10'd4;
         h          = 10'd4;
         filterType = 1'b0;
         delta      = (i % 2 == 0) ? 10'sd39 : 10'sd40;
         @(posedge clk);
         #1;
         exp_up = (i % 2 == 0);
         n_cmp++;
         if (out_valid !== 1'b1 || useUpsample !== exp_up) begin
            n_err++;
            $display("FAIL b2b[%0d]: got vld=%b up=%b expected vld=1 up=%b",
                     i, out_valid, useUpsample, exp_up);
         end
      end
   endtask

   task automatic test_gap();
      in_valid = 1'b1; w = 10'd4; h = 10'd4; filterType = 1'b0; delta = 10'sd20;
      @(posedge clk);
      #1;
      exp_up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid   = 1'b0;
         w          = 'x;
         h          = 'x;
         filterType = 1'bx;
         delta      = 'x;
         @(posedge clk);
         #1;
         n_cmp++;
         if (out_valid !== 1'b0 || useUpsample !== exp_up) begin
            n_err++;
            $display("FAIL gap[%0d]: got vld=%b up=%b expected vld=0 up=%b",
                     i, out_valid, useUpsample, exp_up);
         end
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; w = 10'd4; h = 10'd4; filterType = 1'b0; delta = -10'sd39;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || useUpsample !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_pre: got vld=%b up=%b expected vld=1 up=1", out_valid, useUpsample);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || useUpsample !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_async: got vld=%b up=%b expected vld=0 up=0", out_valid, useUpsample);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || useUpsample !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_held: got vld=%b up=%b expected vld=0 up=0", out_valid, useUpsample);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_up = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b1 || useUpsample !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_post: got vld=%b up=%b expected vld=1 up=1", out_valid, useUpsample);
      end
   endtask

   task automatic test_random();
      logic exp_vld;
      for (int i = 0; i < 400; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         w          = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(4, 64))
                                                  : 10'(4 << $urandom_range(0, 2));
         h          = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(4, 64))
                                                  : 10'(4 << $urandom_range(0, 2));
         filterType = 1'($urandom_range(0, 1));
         delta      = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 1023))
                                                  : 10'($urandom_range(0, 100) - 50);
         delta_left = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 1023))
                                                  : 10'($urandom_range(0, 100) - 50);
         exp_vld = in_valid;
         if (in_valid) begin
            exp_up   = ref_upsample(int'(w), int'(h), filterType, int'(delta));
            exp_left = ref_upsample(int'(w), int'(h), filterType, int'(delta_left));
         end
         @(posedge clk);
         #1;
         n_cmp++;
         if (out_valid !== exp_vld || useUpsample !== exp_up) begin
            n_err++;
            $display("FAIL random[%0d]: got vld=%b up=%b expected vld=%b up=%b",
                     i, out_valid, useUpsample, exp_vld, exp_up);
         end
`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
         n_cmp++;
         if (useUpsampleLeft !== exp_left) begin
            n_err++;
            $display("FAIL random_left[%0d]: got %b expected %b", i, useUpsampleLeft, exp_left);
         end
`endif
      end
   endtask

`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
   task automatic test_dual();
      in_valid = 1'b1; w = 10'd4; h = 10'd4; filterType = 1'b0;
      delta = 10'sd39; delta_left = -10'sd41;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || useUpsample !== 1'b1 || useUpsampleLeft !== 1'b0) begin
         n_err++;
         $display("FAIL dual: got vld=%b up=%b left=%b expected vld=1 up=1 left=0",
                  out_valid, useUpsample, useUpsampleLeft);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_gap();
      test_reset_mid();
`ifdef INTRA_EDGE_UPSAMPLE_DUAL_EN
      test_dual();
`endif
      test_random();
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
